// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR scoreboard and its write-port arbiter.
package gpr_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_IW = $clog2(NREG);

  // Writeback requesters competing for the single register-file write port.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the ALU and LSU writeback paths.
// A lone requester is always granted; on contention the prio requester wins
// and prio passes to the loser so it wins the next contended cycle.
module rr_arb2
  import gpr_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  req_e prio_q, prio_d;

  // Grant decode and priority rotation on contention.
  always_comb begin
    gnt_alu = req_alu && (!req_lsu || (prio_q == REQ_ALU));
    gnt_lsu = req_lsu && (!req_alu || (prio_q == REQ_LSU));
    prio_d  = prio_q;
    if (req_alu && req_lsu) begin
      prio_d = (prio_q == REQ_ALU) ? REQ_LSU : REQ_ALU;
    end
  end

  // Priority register, synchronous active-low reset to LSU.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_q <= REQ_LSU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/gpr_scoreboard.sv
// Issue-side busy-bit scoreboard with RAW/WAW stall generation, plus the
// write-port mux that shares the register file between ALU and LSU writebacks.
module gpr_scoreboard
  import gpr_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  // Decode / issue
  input  logic              id_valid,
  input  logic [REG_IW-1:0] id_rs1,
  input  logic [REG_IW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rd_wen,
  input  logic [REG_IW-1:0] id_rd,
  output logic              id_stall,
  // ALU writeback
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [REG_IW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  // LSU writeback
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [REG_IW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  // Register file write port
  output logic              rf_wr_en,
  output logic [REG_IW-1:0] rf_index_rd,
  output logic [XLEN-1:0]   rf_data_rd,
  // Status
  output logic [NREG-1:0]   busy_vec,
  output logic              wb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_err_q, wb_err_d;
  logic            gnt_alu, gnt_lsu;
  logic            wb_gnt;
  logic            issue_set;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req_alu (alu_wb_valid),
    .req_lsu (lsu_wb_valid),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  // Hazard detection: stall while any used source or the destination is in flight.
  always_comb begin
    id_stall = id_valid &&
               ((id_rs1_used && busy_q[id_rs1]) ||
                (id_rs2_used && busy_q[id_rs2]) ||
                (id_rd_wen   && busy_q[id_rd]));
  end

  // Write-port mux; rd=0 writebacks are accepted but never write.
  always_comb begin
    alu_wb_ready = gnt_alu;
    lsu_wb_ready = gnt_lsu;
    wb_gnt       = gnt_alu || gnt_lsu;
    rf_index_rd  = gnt_alu ? alu_wb_rd   : lsu_wb_rd;
    rf_data_rd   = gnt_alu ? alu_wb_data : lsu_wb_data;
    rf_wr_en     = wb_gnt && (rf_index_rd != '0);
  end

  // Busy-bit and error-flag next state; set and clear hit different bits.
  always_comb begin
    issue_set = id_valid && !id_stall && id_rd_wen && (id_rd != '0);
    busy_d    = busy_q;
    wb_err_d  = wb_err_q;
    if (rf_wr_en) begin
      busy_d[rf_index_rd] = 1'b0;
      if (!busy_q[rf_index_rd]) begin
        wb_err_d = 1'b1;
      end
    end
    if (issue_set) begin
      busy_d[id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed plus randomized bench for gpr_scoreboard against a set-based model.
module tb_gpr_scoreboard;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_wen;
  logic        id_stall;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [63:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [63:0] lsu_wb_data;
  logic        rf_wr_en;
  logic [4:0]  rf_index_rd;
  logic [63:0] rf_data_rd;
  logic [31:0] busy_vec;
  logic        wb_err;

  gpr_scoreboard dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd_wen    (id_rd_wen),
    .id_rd        (id_rd),
    .id_stall     (id_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .rf_wr_en     (rf_wr_en),
    .rf_index_rd  (rf_index_rd),
    .rf_data_rd   (rf_data_rd),
    .busy_vec     (busy_vec),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: set of in-flight destination registers, who wins next tie, error flag.
  bit in_flight[32];
  bit lsu_next;
  bit m_err;

  // Expectations of the current cycle, used again at the clock edge.
  bit        e_stall, e_ag, e_lg;
  bit [4:0]  e_rd;
  bit [63:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_wen = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  task automatic issue(input bit wen, input bit [4:0] rd, input bit u1, input bit [4:0] r1);
    id_valid = 1; id_rd_wen = wen; id_rd = rd;
    id_rs1_used = u1; id_rs1 = r1; id_rs2_used = 0; id_rs2 = 0;
  endtask

  // Move to the falling edge and compare every output against the model.
  task automatic settle();
    bit [31:0] e_busy;
    #4;
    e_stall = id_valid && ((id_rs1_used && in_flight[id_rs1]) ||
                           (id_rs2_used && in_flight[id_rs2]) ||
                           (id_rd_wen && in_flight[id_rd]));
    if (alu_wb_valid && lsu_wb_valid) begin
      e_lg = lsu_next;
      e_ag = !lsu_next;
    end else begin
      e_ag = alu_wb_valid;
      e_lg = lsu_wb_valid;
    end
    e_rd   = e_ag ? alu_wb_rd : lsu_wb_rd;
    e_data = e_ag ? alu_wb_data : lsu_wb_data;
    for (int r = 0; r < 32; r++) e_busy[r] = in_flight[r];
    chk("id_stall", id_stall, e_stall);
    chk("alu_wb_ready", alu_wb_ready, e_ag);
    chk("lsu_wb_ready", lsu_wb_ready, e_lg);
    chk("rf_wr_en", rf_wr_en, (e_ag || e_lg) && e_rd != 0);
    if (e_ag || e_lg) begin
      chk("rf_index_rd", rf_index_rd, e_rd);
      chk("rf_data_rd", rf_data_rd, e_data);
    end
    chk("busy_vec", busy_vec, e_busy);
    chk("wb_err", wb_err, m_err);
  endtask

  // Clock edge: update the model, retire granted requests, step past the edge.
  task automatic advance();
    @(posedge clk);
    if (!rstn) begin
      for (int r = 0; r < 32; r++) in_flight[r] = 0;
      lsu_next = 1;
      m_err = 0;
      alu_wb_valid = 0;
      lsu_wb_valid = 0;
    end else begin
      if ((e_ag || e_lg) && e_rd != 0) begin
        if (!in_flight[e_rd]) m_err = 1;
        in_flight[e_rd] = 0;
      end
      if (alu_wb_valid && lsu_wb_valid) lsu_next = !lsu_next;
      if (id_valid && !e_stall && id_rd_wen && id_rd != 0) in_flight[id_rd] = 1;
      #1;
      if (e_ag) alu_wb_valid = 0;
      if (e_lg) lsu_wb_valid = 0;
    end
    if (!rstn) #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    step();
    step();
    rstn = 1;
  endtask

  initial begin
    bit [4:0] cand[$];
    rstn = 0;
    lsu_next = 1;
    m_err = 0;
    idle();
    @(posedge clk);
    #1;

    // Reset
    do_reset();
    settle();
    chk("reset_busy", busy_vec, 0);
    chk("reset_err", wb_err, 0);
    chk("reset_rf_wr_en", rf_wr_en, 0);
    advance();

    // RAW on x5, cleared by ALU writeback of 0xDEAD
    issue(1, 5, 0, 0); step();
    issue(0, 0, 1, 5); settle(); chk("raw_stall", id_stall, 1); advance();
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'hDEAD;
    settle();
    chk("raw_wb_en", rf_wr_en, 1);
    chk("raw_wb_idx", rf_index_rd, 5);
    chk("raw_stall_same_cycle", id_stall, 1);
    advance();
    settle(); chk("raw_stall_released", id_stall, 0); advance();

    // WAW on x7
    issue(1, 7, 0, 0); step();
    issue(1, 7, 0, 0); settle(); chk("waw_stall", id_stall, 1); advance();
    lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 64'h77;
    step();
    settle(); chk("waw_released", id_stall, 0); advance();
    idle();
    alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 64'h78;
    step();
    // x0 destination and x0 source never stall or set busy
    idle();
    issue(1, 0, 1, 0); id_rs2_used = 1; settle(); chk("x0_no_stall", id_stall, 0); advance();
    idle(); settle(); chk("x0_busy_clear", busy_vec, 0); advance();

    // Contention: x3..x6 busy, both sources valid for four cycles
    do_reset();
    issue(1, 3, 0, 0); step();
    issue(1, 4, 0, 0); step();
    issue(1, 5, 0, 0); step();
    issue(1, 6, 0, 0); step();
    idle();
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 64'hA3;
    lsu_wb_valid = 1; lsu_wb_rd = 4; lsu_wb_data = 64'hB4;
    settle(); chk("cont1_lsu", lsu_wb_ready, 1); chk("cont1_alu", alu_wb_ready, 0); advance();
    lsu_wb_valid = 1; lsu_wb_rd = 6; lsu_wb_data = 64'hB6;
    settle(); chk("cont2_alu", alu_wb_ready, 1); chk("cont2_data", rf_data_rd, 64'hA3); advance();
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'hA5;
    settle(); chk("cont3_lsu", lsu_wb_ready, 1); chk("cont3_alu", alu_wb_ready, 0); advance();
    // LSU writeback to x0 is accepted without a write
    lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_data = 64'hB0;
    settle(); chk("cont4_alu", alu_wb_ready, 1); advance();
    settle(); chk("x0_wb_ready", lsu_wb_ready, 1); chk("x0_wb_noen", rf_wr_en, 0); advance();
    settle(); chk("x0_wb_noerr", wb_err, 0); advance();

    // Error flag: writeback to idle x9
    alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 64'h99;
    step();
    settle(); chk("err_set", wb_err, 1); advance();
    step(); step();
    do_reset();
    settle(); chk("err_cleared", wb_err, 0); advance();

    // Randomized traffic; sources only write back registers that are in flight
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid = 1'($urandom_range(0, 1));
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      id_rd_wen = 1'($urandom_range(0, 1));
      if (!alu_wb_valid && $urandom_range(0, 2) == 0) begin
        cand.delete();
        for (int r = 1; r < 32; r++)
          if (in_flight[r] && !(lsu_wb_valid && lsu_wb_rd == 5'(r))) cand.push_back(5'(r));
        if ($urandom_range(0, 7) == 0) cand.push_back(5'd0);
        if (cand.size() > 0) begin
          alu_wb_valid = 1;
          alu_wb_rd = cand[$urandom_range(0, cand.size() - 1)];
          alu_wb_data = {$urandom, $urandom};
        end
      end
      if (!lsu_wb_valid && $urandom_range(0, 2) == 0) begin
        cand.delete();
        for (int r = 1; r < 32; r++)
          if (in_flight[r] && !(alu_wb_valid && alu_wb_rd == 5'(r))) cand.push_back(5'(r));
        if ($urandom_range(0, 7) == 0) cand.push_back(5'd0);
        if (cand.size() > 0) begin
          lsu_wb_valid = 1;
          lsu_wb_rd = cand[$urandom_range(0, cand.size() - 1)];
          lsu_wb_data = {$urandom, $urandom};
        end
      end
      step();
      if (cyc == 200) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
